// File: rtl/layer7_feature_reader.sv
// -----------------------------------------------------------------------------
// layer7_feature_reader
//
// Read-side sequencer for the layer-6 result buffer. After a start pulse it
// walks the MAP_H x MAP_W result map in row-major order through the buffer's
// combinational read port, registers each returned word and streams it to the
// layer-7 datapath over a valid/ready handshake. The final word is tagged with
// out_last and a one-cycle done pulse follows its acceptance.
//
// Optional feature (compile-time macro LAYER7_READER_ZERO_PAD_EN):
//   The scan is widened to (MAP_H+2) x (MAP_W+2) positions so the stream
//   carries a one-element zero border around the map. Border positions do not
//   touch the buffer (read signal low) and stream a zero word; interior
//   position (r,c) reads buffer address (r-1,c-1).
//
// Parameters:
//   DATA_W  width of one stored result word
//   MAP_W   map columns, 1..5
//   MAP_H   map rows,    1..5
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start                       one-cycle pulse, begin streaming one map
//   read_row_addr/read_col_addr buffer read address (bits [15:3] always 0)
//   layer6_result_read_signal   buffer read enable
//   layer6_result_output        combinational read data from the buffer
//   out_data/out_valid/out_last streamed word, registered
//   out_ready                   consumer accepts the word
//   busy                        high while a map is being streamed
//   done                        one-cycle pulse after the last word transfers
// -----------------------------------------------------------------------------

`ifndef LAYER7_WEIGHT_INPUT_LENGTH
`define LAYER7_WEIGHT_INPUT_LENGTH 8
`endif

module layer7_feature_reader #(
   parameter int DATA_W = `LAYER7_WEIGHT_INPUT_LENGTH,
   parameter int MAP_W  = 5,
   parameter int MAP_H  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [15:0]       read_row_addr,
   output logic [15:0]       read_col_addr,
   output logic              layer6_result_read_signal,
   input  logic [DATA_W-1:0] layer6_result_output,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last,
   output logic              busy,
   output logic              done
);

`ifdef LAYER7_READER_ZERO_PAD_EN
   localparam int SCAN_H = MAP_H + 2;
   localparam int SCAN_W = MAP_W + 2;
`else
   localparam int SCAN_H = MAP_H;
   localparam int SCAN_W = MAP_W;
`endif

   localparam logic [2:0] LAST_ROW = 3'(SCAN_H - 1);
   localparam logic [2:0] LAST_COL = 3'(SCAN_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_t;

   state_t            state;
   logic [2:0]        row;
   logic [2:0]        col;

   logic              in_run;
   logic              load;
   logic              at_last;
   logic              fetch;
   logic [2:0]        buf_row;
   logic [2:0]        buf_col;
   logic [DATA_W-1:0] fetch_data;

   assign in_run  = (state == RUN);
   // The output register may be refilled when it is empty or its word is
   // leaving this very cycle; this gives one word per cycle under out_ready=1.
   assign load    = in_run && (!out_valid || out_ready);
   assign at_last = (row == LAST_ROW) && (col == LAST_COL);

`ifdef LAYER7_READER_ZERO_PAD_EN
   logic on_border;

   assign on_border  = (row == 3'd0) || (row == LAST_ROW) ||
                       (col == 3'd0) || (col == LAST_COL);
   assign fetch      = in_run && !on_border;
   assign buf_row    = fetch ? row - 3'd1 : 3'd0;
   assign buf_col    = fetch ? col - 3'd1 : 3'd0;
   // Border words are synthesised here; the buffer is not read for them.
   assign fetch_data = fetch ? layer6_result_output : '0;
`else
   assign fetch      = in_run;
   assign buf_row    = fetch ? row : 3'd0;
   assign buf_col    = fetch ? col : 3'd0;
   assign fetch_data = layer6_result_output;
`endif

   // Read port is driven straight from the scan counters so the buffer's
   // combinational data is ready to be captured on the same edge.
   assign layer6_result_read_signal = fetch;
   assign read_row_addr             = {13'b0, buf_row};
   assign read_col_addr             = {13'b0, buf_col};
   assign busy                      = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: the output data register is reset along with the control
         // state because every output must read zero during and after reset.
         state     <= IDLE;
         row       <= 3'd0;
         col       <= 3'd0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // sees the pre-edge values of row/col/out_valid regardless of order.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  row   <= 3'd0;
                  col   <= 3'd0;
               end
            end

            RUN: begin
               if (load) begin
                  out_data  <= fetch_data;
                  out_valid <= 1'b1;
                  out_last  <= at_last;
                  if (at_last) begin
                     state <= DRAIN;
                  end else if (col == LAST_COL) begin
                     col <= 3'd0;
                     row <= row + 3'd1;
                  end else begin
                     col <= col + 3'd1;
                  end
               end
            end

            DRAIN: begin
               // Only the final word can be outstanding here.
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_layer7_feature_reader.sv
// -----------------------------------------------------------------------------
// tb_layer7_feature_reader
//
// Scoreboard bench for layer7_feature_reader. Each accepted start pushes the
// full expected word stream (derived from the buffer contents and the scan
// order, with the zero border when LAYER7_READER_ZERO_PAD_EN is defined) into
// a queue; an independent monitor pops and compares on every transfer, checks
// stall stability, the done pulse and busy.
// -----------------------------------------------------------------------------

`ifndef LAYER7_WEIGHT_INPUT_LENGTH
`define LAYER7_WEIGHT_INPUT_LENGTH 8
`endif

module tb_layer7_feature_reader;

   localparam int DATA_W = `LAYER7_WEIGHT_INPUT_LENGTH;
   localparam int MAP_W  = 5;
   localparam int MAP_H  = 5;
`ifdef LAYER7_READER_ZERO_PAD_EN
   localparam int PAD = 1;
`else
   localparam int PAD = 0;
`endif
   localparam int SCAN_W = MAP_W + 2 * PAD;
   localparam int SCAN_H = MAP_H + 2 * PAD;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   logic              clk;
   logic              rst;
   logic              start;
   logic [15:0]       read_row_addr;
   logic [15:0]       read_col_addr;
   logic              layer6_result_read_signal;
   logic [DATA_W-1:0] layer6_result_output;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] mem [MAP_H][MAP_W];
   beat_t             sb[$];

   int n_checks = 0;
   int n_pass   = 0;
   int beats    = 0;
   int done_cnt = 0;
   int ready_mode = 0;

   layer7_feature_reader #(
      .DATA_W(DATA_W),
      .MAP_W (MAP_W),
      .MAP_H (MAP_H)
   ) dut (
      .clk                       (clk),
      .rst                       (rst),
      .start                     (start),
      .read_row_addr             (read_row_addr),
      .read_col_addr             (read_col_addr),
      .layer6_result_read_signal (layer6_result_read_signal),
      .layer6_result_output      (layer6_result_output),
      .out_data                  (out_data),
      .out_valid                 (out_valid),
      .out_ready                 (out_ready),
      .out_last                  (out_last),
      .busy                      (busy),
      .done                      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Buffer model: combinational read; returns all-ones junk when not enabled
   // or out of range, so a padded position that wrongly uses the bus shows up.
   always_comb begin
      layer6_result_output = '1;
      if (layer6_result_read_signal && read_row_addr < 16'(MAP_H) &&
          read_col_addr < 16'(MAP_W))
         layer6_result_output = mem[read_row_addr[2:0]][read_col_addr[2:0]];
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                    name, act, exp, $time);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_data"},  64'(out_data),  64'd0);
      check({tag, "_last"},  64'(out_last),  64'd0);
      check({tag, "_busy"},  64'(busy),      64'd0);
      check({tag, "_done"},  64'(done),      64'd0);
      check({tag, "_rd"},    64'(layer6_result_read_signal), 64'd0);
      check({tag, "_row"},   64'(read_row_addr), 64'd0);
      check({tag, "_col"},   64'(read_col_addr), 64'd0);
   endtask

   // Reference model: expected stream for one map from current buffer contents.
   task automatic push_stream();
      for (int r = 0; r < SCAN_H; r++) begin
         for (int c = 0; c < SCAN_W; c++) begin
            beat_t b;
            int    mr;
            int    mc;
            mr = r - PAD;
            mc = c - PAD;
            if (mr < 0 || mr >= MAP_H || mc < 0 || mc >= MAP_W) b.data = '0;
            else b.data = mem[mr[2:0]][mc[2:0]];
            b.last = (r == SCAN_H - 1) && (c == SCAN_W - 1);
            sb.push_back(b);
         end
      end
   endtask

   task automatic fill_mem(input bit random_fill);
      for (int r = 0; r < MAP_H; r++)
         for (int c = 0; c < MAP_W; c++)
            mem[r][c] = random_fill ? DATA_W'($urandom) : DATA_W'(r * 16 + c);
   endtask

   task automatic start_stream();
      @(negedge clk);
      start = 1'b1;
      push_stream();
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit restart);
      int n;
      n = 0;
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 64'(done), 64'd1);
      check("sb_empty", 64'(sb.size()), 64'd0);
      if (restart) begin
         // start coincides with the done pulse: must be accepted
         start = 1'b1;
         push_stream();
         @(negedge clk);
         start = 1'b0;
      end else begin
         @(negedge clk);
      end
   endtask

   task automatic wait_beats(input int target);
      int n;
      n = 0;
      while (beats < target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("beats_reached", 64'(beats >= target), 64'd1);
   endtask

   // Consumer ready pattern: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random.
   initial begin
      int rcnt;
      rcnt      = 0;
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         rcnt++;
      end
   end

   // Monitor: sampled on the falling edge, i.e. the values the next rising
   // edge will act on.
   initial begin
      beat_t             e;
      bit                expect_done;
      bit                stall_pend;
      logic [DATA_W-1:0] held_data;
      logic              held_last;
      logic [15:0]       held_row;
      logic [15:0]       held_col;
      logic              held_rd;
      expect_done = 1'b0;
      stall_pend  = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            expect_done = 1'b0;
            stall_pend  = 1'b0;
         end else begin
            if (done === 1'b1) done_cnt++;
            check("done_pulse", 64'(done), 64'(expect_done));
            if (expect_done) check("busy_with_done", 64'(busy), 64'd0);
            expect_done = 1'b0;

            if (stall_pend) begin
               check("stall_data", 64'(out_data), 64'(held_data));
               check("stall_last", 64'(out_last), 64'(held_last));
               check("stall_row",  64'(read_row_addr), 64'(held_row));
               check("stall_col",  64'(read_col_addr), 64'(held_col));
               check("stall_rd",   64'(layer6_result_read_signal), 64'(held_rd));
            end
            stall_pend = 1'b0;

            if (out_valid === 1'b1) begin
               if (out_ready) begin
                  if (sb.size() == 0) begin
                     check("extra_beat", 64'(out_data), 64'hDEAD);
                  end else begin
                     e = sb.pop_front();
                     check("beat_data", 64'(out_data), 64'(e.data));
                     check("beat_last", 64'(out_last), 64'(e.last));
                     beats++;
                  end
                  if (out_last) expect_done = 1'b1;
               end else begin
                  stall_pend = 1'b1;
                  held_data  = out_data;
                  held_last  = out_last;
                  held_row   = read_row_addr;
                  held_col   = read_col_addr;
                  held_rd    = layer6_result_read_signal;
               end
            end
         end
      end
   end

   initial begin
      int b0;
      int dc;
      rst        = 1'b1;
      start      = 1'b0;
      ready_mode = 0;
      fill_mem(1'b0);

      // Reset and idle
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check_idle("idle");

      // Full-rate stream with row*16+col contents, plus start latency
      start_stream();
      check("lat_busy", 64'(busy), 64'd1);
      check("lat_valid0", 64'(out_valid), 64'd0);
      @(negedge clk);
      check("lat_valid1", 64'(out_valid), 64'd1);
      wait_done(1000, 1'b0);

      // Ready toggling 1,0,0,1; then a start coincident with done
      ready_mode = 1;
      start_stream();
      wait_done(1000, 1'b1);
      wait_done(1000, 1'b0);

      // Random contents, random ready, start re-pulsed mid-stream
      fill_mem(1'b1);
      ready_mode = 2;
      b0 = beats;
      dc = done_cnt;
      start_stream();
      wait_beats(b0 + 10);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(1000, 1'b0);
      repeat (5) @(negedge clk);
      check("one_done", 64'(done_cnt - dc), 64'd1);
      check("beat_count", 64'(beats - b0), 64'(SCAN_W * SCAN_H));

      // Reset mid-stream, then a fresh stream from the first word
      fill_mem(1'b0);
      b0 = beats;
      dc = done_cnt;
      start_stream();
      wait_beats(b0 + 12);
      #2 rst = 1'b1;
      #1 check_idle("mid_rst");
      sb.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("no_done", 64'(done_cnt - dc), 64'd0);
      check_idle("post_rst");
      ready_mode = 0;
      start_stream();
      wait_done(1000, 1'b0);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
